// File: rtl/rr_arbiter_ctrl.sv
// rr_arbiter_ctrl: registered four-way round-robin arbiter with hold limit and forced-release pulse.
module rr_arbiter_ctrl #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       enable_i,
  input  logic [3:0] req_i,
  input  logic [3:0] done_i,
  output logic [3:0] gnt_o,
  output logic       gnt_valid_o,
  output logic [1:0] gnt_id_o,
  output logic       timeout_o
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t           state_q, state_d;
  logic [1:0]       last_q, last_d, gnt_id_q, gnt_id_d, win;
  logic [3:0]       gnt_q, gnt_d;
  logic             gnt_valid_q, gnt_valid_d, timeout_q, timeout_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             release_now, expire_now;
  // Scan from farthest to nearest so the requester right after last wins.
  always_comb begin
    win = last_q;
    for (int k = 4; k >= 1; k--) if (req_i[last_q + 2'(k)]) win = last_q + 2'(k);
  end
  assign release_now = !enable_i || done_i[last_q] || !req_i[last_q];
  assign expire_now  = hold_cnt_q == CNT_W'(MAX_HOLD);
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    hold_cnt_d  = hold_cnt_q;
    timeout_d   = 1'b0;
    if (state_q == IDLE) begin
      if (enable_i && |req_i) begin
        state_d     = BUSY;
        gnt_d       = 4'b1 << win;
        gnt_id_d    = win;
        gnt_valid_d = 1'b1;
        last_d      = win;
        hold_cnt_d  = CNT_W'(1);
      end
    end else if (release_now || expire_now) begin
      state_d     = IDLE;
      gnt_d       = '0;
      gnt_id_d    = '0;
      gnt_valid_d = 1'b0;
      hold_cnt_d  = '0;
      timeout_d   = !release_now;
    end else begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      last_q      <= 2'd3;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end
  assign gnt_o       = gnt_q;
  assign gnt_valid_o = gnt_valid_q;
  assign gnt_id_o    = gnt_id_q;
  assign timeout_o   = timeout_q;
endmodule

// File: tb/tb_rr_arbiter_ctrl.sv
// tb_rr_arbiter_ctrl: vector table, corner sequences and random traffic against a reference model.
module tb_rr_arbiter_ctrl;
  localparam int MAX_HOLD = 8;
  logic       clk, rst_n, en;
  logic [3:0] req, done, gnt;
  logic       gnt_valid, to;
  logic [1:0] gnt_id;
  int         n_cmp = 0, n_err = 0;
  int         m_owner, m_last, m_held;
  bit         m_to;
  rr_arbiter_ctrl #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .req_i(req), .done_i(done),
    .gnt_o(gnt), .gnt_valid_o(gnt_valid), .gnt_id_o(gnt_id), .timeout_o(to)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  typedef struct {
    logic       en;
    logic [3:0] req, done, gnt;
    logic [1:0] id;
    logic       to;
  } vec_t;
  vec_t tbl[25];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  task automatic model_reset();
    m_owner = -1;
    m_last  = 3;
    m_held  = 0;
    m_to    = 0;
  endtask
  task automatic model_step();
    m_to = 0;
    if (m_owner < 0) begin
      if (en && req != 0)
        for (int k = 1; k <= 4; k++)
          if (m_owner < 0 && req[(m_last + k) % 4]) begin
            m_owner = (m_last + k) % 4;
            m_last  = m_owner;
            m_held  = 1;
          end
    end else if (!en || done[m_owner] || !req[m_owner]) m_owner = -1;
    else if (m_held == MAX_HOLD) begin
      m_owner = -1;
      m_to    = 1;
    end else m_held++;
  endtask
  task automatic chk_model(input string name);
    chk({name, "_gnt"}, gnt, m_owner < 0 ? 0 : (1 << m_owner));
    chk({name, "_id"}, gnt_id, m_owner < 0 ? 0 : m_owner);
    chk({name, "_valid"}, gnt_valid, m_owner >= 0);
    chk({name, "_timeout"}, to, m_to);
  endtask
  task automatic cycle(input string name);
    model_step();
    @(posedge clk);
    #1;
    chk_model(name);
    chk({name, "_onehot"}, $countones(gnt) <= 1, 1);
  endtask
  initial begin
    rst_n = 0; en = 0; req = 0; done = 0;
    model_reset();
    #12;
    chk("reset_gnt", gnt, 0);
    chk("reset_valid", gnt_valid, 0);
    chk("reset_id", gnt_id, 0);
    chk("reset_timeout", to, 0);
    rst_n = 1;
    @(posedge clk);
    #1;
    tbl[0]  = '{1'b1, 4'hF, 4'h0, 4'h1, 2'd0, 1'b0};
    tbl[1]  = '{1'b1, 4'hF, 4'h0, 4'h1, 2'd0, 1'b0};
    tbl[2]  = '{1'b1, 4'hF, 4'h1, 4'h0, 2'd0, 1'b0};
    tbl[3]  = '{1'b1, 4'hF, 4'h0, 4'h2, 2'd1, 1'b0};
    tbl[4]  = '{1'b1, 4'hF, 4'h0, 4'h2, 2'd1, 1'b0};
    tbl[5]  = '{1'b1, 4'hF, 4'h2, 4'h0, 2'd0, 1'b0};
    tbl[6]  = '{1'b1, 4'hF, 4'h0, 4'h4, 2'd2, 1'b0};
    tbl[7]  = '{1'b1, 4'hF, 4'h0, 4'h4, 2'd2, 1'b0};
    tbl[8]  = '{1'b1, 4'hF, 4'h4, 4'h0, 2'd0, 1'b0};
    tbl[9]  = '{1'b1, 4'hF, 4'h0, 4'h8, 2'd3, 1'b0};
    tbl[10] = '{1'b1, 4'hF, 4'h0, 4'h8, 2'd3, 1'b0};
    tbl[11] = '{1'b1, 4'hF, 4'h8, 4'h0, 2'd0, 1'b0};
    tbl[12] = '{1'b1, 4'hF, 4'h0, 4'h1, 2'd0, 1'b0};
    tbl[13] = '{1'b0, 4'hF, 4'h0, 4'h0, 2'd0, 1'b0};
    tbl[14] = '{1'b0, 4'hF, 4'h0, 4'h0, 2'd0, 1'b0};
    tbl[15] = '{1'b0, 4'hF, 4'h0, 4'h0, 2'd0, 1'b0};
    tbl[16] = '{1'b0, 4'hF, 4'h0, 4'h0, 2'd0, 1'b0};
    tbl[17] = '{1'b0, 4'hF, 4'h0, 4'h0, 2'd0, 1'b0};
    tbl[18] = '{1'b1, 4'hA, 4'h0, 4'h2, 2'd1, 1'b0};
    tbl[19] = '{1'b0, 4'hA, 4'h0, 4'h0, 2'd0, 1'b0};
    tbl[20] = '{1'b1, 4'hA, 4'h0, 4'h8, 2'd3, 1'b0};
    tbl[21] = '{1'b1, 4'h4, 4'h0, 4'h0, 2'd0, 1'b0};
    tbl[22] = '{1'b1, 4'h4, 4'h0, 4'h4, 2'd2, 1'b0};
    tbl[23] = '{1'b1, 4'h4, 4'h1, 4'h4, 2'd2, 1'b0};
    tbl[24] = '{1'b1, 4'h0, 4'h0, 4'h0, 2'd0, 1'b0};
    for (int i = 0; i < 25; i++) begin
      en = tbl[i].en; req = tbl[i].req; done = tbl[i].done;
      cycle($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_tgnt", i), gnt, tbl[i].gnt);
      chk($sformatf("vec%0d_tid", i), gnt_id, tbl[i].id);
      chk($sformatf("vec%0d_tvalid", i), gnt_valid, tbl[i].gnt != 0);
      chk($sformatf("vec%0d_tto", i), to, tbl[i].to);
    end
    en = 1; req = 4'h4; done = 0;
    for (int i = 0; i < MAX_HOLD; i++) begin
      cycle("hold");
      chk("hold_gnt", gnt, 4'h4);
      chk("hold_timeout", to, 0);
    end
    cycle("expire");
    chk("expire_gnt", gnt, 0);
    chk("expire_timeout", to, 1);
    cycle("regrant");
    chk("regrant_gnt", gnt, 4'h4);
    chk("regrant_timeout", to, 0);
    req = 4'h8;
    cycle("drop2");
    cycle("own3");
    chk("own3_gnt", gnt, 4'h8);
    #2 rst_n = 0;
    model_reset();
    #1;
    chk("async_gnt", gnt, 0);
    chk("async_valid", gnt_valid, 0);
    chk("async_id", gnt_id, 0);
    chk("async_timeout", to, 0);
    req = 4'h9;
    #2 rst_n = 1;
    cycle("post_reset");
    chk("post_reset_gnt", gnt, 4'h1);
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(9) != 0);
      req = 4'($urandom);
      done = ($urandom_range(3) == 0) ? 4'($urandom) : 4'h0;
      if ($urandom_range(3) != 0) req = req | gnt;
      cycle("rand");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
